// File: rtl/pe_mac_seq_if.sv
// Bundle between the pe_mac operand sequencer and its surroundings: command, operand stream, PE link and result port.
// With PE_SEQ_BIAS_EN defined, a bias operand is added alongside the start command.
interface pe_mac_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 7
);
    // op_* and res_* are valid/ready pairs: a beat transfers on any rising clk where valid && ready,
    // the producer holds valid and data stable until that beat, and ready may not wait on valid.
    logic                  start;
    logic [LEN_W-1:0]      len;
    logic                  busy;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  pe_valid_in;
    logic [DATA_WIDTH-1:0] pe_a;
    logic [DATA_WIDTH-1:0] pe_b;
    logic [DATA_WIDTH-1:0] pe_acc;
    logic [DATA_WIDTH-1:0] pe_result;
    logic                  pe_valid_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [1:0]            dbg_state;
`ifdef PE_SEQ_BIAS_EN
    logic [DATA_WIDTH-1:0] bias;

    modport master (
        input  start, len, bias, op_valid, op_a, op_b, pe_result, pe_valid_out, res_ready,
        output busy, op_ready, pe_valid_in, pe_a, pe_b, pe_acc, res_valid, res_data, dbg_state
    );
    modport slave (
        output start, len, bias, op_valid, op_a, op_b, pe_result, pe_valid_out, res_ready,
        input  busy, op_ready, pe_valid_in, pe_a, pe_b, pe_acc, res_valid, res_data, dbg_state
    );
`else
    modport master (
        input  start, len, op_valid, op_a, op_b, pe_result, pe_valid_out, res_ready,
        output busy, op_ready, pe_valid_in, pe_a, pe_b, pe_acc, res_valid, res_data, dbg_state
    );
    modport slave (
        output start, len, op_valid, op_a, op_b, pe_result, pe_valid_out, res_ready,
        input  busy, op_ready, pe_valid_in, pe_a, pe_b, pe_acc, res_valid, res_data, dbg_state
    );
`endif
endinterface

// File: rtl/pe_mac_seq.sv
// Operand sequencer for one pe_mac PE: streams len operand pairs through the PE and returns the dot product.
// Optional PE_SEQ_BIAS_EN seeds the first term (and the len=0 result) with a bias latched on start.
module pe_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int VEC_LEN    = 64,
    parameter int LEN_W      = $clog2(VEC_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    pe_mac_seq_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] res_q;

    logic                  beat;
    logic                  last_beat;
    logic [LEN_W-1:0]      len_clamped;
    logic [DATA_WIDTH-1:0] init_acc;
    logic [DATA_WIDTH-1:0] empty_res;
    logic [DATA_WIDTH-1:0] acc_sel;

`ifdef PE_SEQ_BIAS_EN
    logic [DATA_WIDTH-1:0] bias_q;

    assign init_acc  = bias_q;
    assign empty_res = bus.bias;
`else
    assign init_acc  = '0;
    assign empty_res = '0;
`endif

    always_comb begin
        beat        = (state_q == RUN) && bus.op_valid;
        last_beat   = beat && (cnt_q == len_q - LEN_W'(1));
        len_clamped = (bus.len > LEN_W'(VEC_LEN)) ? LEN_W'(VEC_LEN) : bus.len;
        // The PE outputs 0 after an idle cycle, so a stalled stream resumes from acc_q.
        if (cnt_q == '0) begin
            acc_sel = init_acc;
        end else if (bus.pe_valid_out) begin
            acc_sel = bus.pe_result;
        end else begin
            acc_sel = acc_q;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.op_ready    = (state_q == RUN);
    assign bus.pe_valid_in = beat;
    assign bus.pe_a        = beat ? bus.op_a : '0;
    assign bus.pe_b        = beat ? bus.op_b : '0;
    assign bus.pe_acc      = (state_q == RUN) ? acc_sel : '0;
    assign bus.res_valid   = (state_q == DONE);
    assign bus.res_data    = res_q;
    assign bus.dbg_state   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
`ifdef PE_SEQ_BIAS_EN
            bias_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_q <= len_clamped;
                        cnt_q <= '0;
                        acc_q <= '0;
`ifdef PE_SEQ_BIAS_EN
                        bias_q <= bus.bias;
`endif
                        if (bus.len == '0) begin
                            res_q   <= empty_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.pe_valid_out) begin
                        acc_q <= bus.pe_result;
                    end
                    if (beat) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                    if (last_beat) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.pe_valid_out) begin
                        acc_q   <= bus.pe_result;
                        res_q   <= bus.pe_result;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pe_mac_seq.md
Name: pe_mac_seq

Overview:
Operand sequencer and initiator for one pe_mac processing element, used in the X_PROJ and delta_t_PROJ phases of the SSM. On a start command, it accepts a stream of len weight/feature pairs. It drives them into the PE one per accepted beat and feeds the partial sum back through acc_in. It then returns the final dot product on a valid/ready result port. The block owns accumulator state, so input-stream stalls never lose a partial sum.

Parameters:
DATA_WIDTH, 16, operand, accumulator and result width; must match the attached PE.
VEC_LEN, 64, maximum number of terms per dot product.
LEN_W, $clog2(VEC_LEN+1), width of the len and count fields.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a dot product; sampled only in IDLE
len  in  LEN_W  number of terms, latched on start
busy  out  1  high in every state except IDLE
op_valid  in  1  operand pair valid
op_ready  out  1  sequencer accepts an operand pair
op_a  in  DATA_WIDTH  signed weight
op_b  in  DATA_WIDTH  signed feature
pe_valid_in  out  1  to PE valid_in
pe_a  out  DATA_WIDTH  to PE a_in
pe_b  out  DATA_WIDTH  to PE b_in
pe_acc  out  DATA_WIDTH  to PE acc_in
pe_result  in  DATA_WIDTH  from PE result_out
pe_valid_out  in  1  from PE valid_out
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  DATA_WIDTH  signed dot product

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, op_ready, pe_valid_in and res_valid are 0.
  - res_data, the accumulator register acc_q, the term counter and len_q are 0.
  - The PE shares the same reset domain.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - start=1 with len=0: go to DONE with res_data=0.
  - start=1 with len>VEC_LEN: len_q is clamped to VEC_LEN.
  - Otherwise start=1 latches len_q, clears the counter and goes to RUN.
- RUN:
  - op_ready=1 (combinational, state-only; it does not depend on op_valid).
  - An accepted beat (op_valid && op_ready) drives pe_valid_in=1, pe_a=op_a and pe_b=op_b combinationally in the same cycle, and increments the counter.
  - pe_acc select:
    - First term: 0.
    - Otherwise, if pe_valid_out=1: pe_result.
    - Otherwise: acc_q.
  - Reason for acc_q: the PE registers 0 when valid_in is low, so acc_q holds the partial sum across gaps.
  - acc_q <= pe_result on every cycle with pe_valid_out=1.
  - When no beat is accepted, pe_valid_in=0 and the operand outputs are 0.
  - The beat where counter reaches len_q-1 is the last issue; go to DRAIN.
- DRAIN:
  - op_ready=0.
  - Wait for pe_valid_out, which arrives exactly 1 cycle after the last issue.
  - On it, res_data <= pe_result and go to DONE.
- DONE:
  - res_valid=1; res_data is held stable until res_ready=1.
  - On the handshake go to IDLE, so busy drops the next cycle.
  - res_valid must not drop without a handshake.
- Latency: if the last beat is accepted in cycle t, res_valid=1 from cycle t+2.
- Throughput: one term per cycle with back-to-back op_valid. A new start is accepted the cycle after the result handshake.
- start outside IDLE is ignored, with no effect on len_q or the counter.
- Arithmetic: no widening or saturation. Wrap-around in the PE's DATA_WIDTH truncation is passed through unchanged.
- Unexpected pe_valid_out in IDLE or DONE is ignored; acc_q and res_data are unchanged.
- Reset mid-operation: abort immediately to IDLE, with the partial result discarded and all outputs at reset values.

Optional Feature:
PE_SEQ_BIAS_EN.
- Defined:
  - Adds input port bias (DATA_WIDTH, signed), latched into bias_q on an accepted start.
  - The first term uses pe_acc=bias_q instead of 0.
  - len=0 returns res_data=bias_q.
- Undefined: no bias port; the first-term acc is 0 and len=0 returns 0.

Test Plan:
1. Back-to-back sum: len=4, op_a={1,2,3,4}, op_b={5,6,7,8}, op_valid continuous -> pe_acc sequence {0,5,17,38}, res_data=70, res_valid exactly 2 cycles after the 4th beat.
2. Stalled stream: same vectors with 3 idle cycles between beats 2 and 3 -> pe_acc for beat 3 = 17 (taken from acc_q), res_data=70.
3. Wrap: len=2, a={0x4000,0x4000}, b={2,2} (DATA_WIDTH=16) -> res_data=0x0000; negative case a={-3,7}, b={4,-2} -> res_data=-26 (0xFFE6).
4. Edge lengths:
   - len=0 -> res_valid the cycle after start with res_data=0.
   - len=VEC_LEN+5 -> exactly VEC_LEN beats accepted, op_ready=0 afterwards.
5. Backpressure and ignored start:
   - Hold res_ready=0 for 5 cycles -> res_valid and res_data stable.
   - start pulsed in RUN and DONE -> ignored.
   - After the handshake, busy=0 the next cycle.
6. Reset mid-RUN: assert rst after 2 of 4 beats -> all outputs 0 asynchronously. A new start with len=1, a=3, b=3 -> res_data=9 (no stale partial sum).
